// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / divide unit.
// Multiply uses radix-2 Booth over DATA_W cycles; divide uses restoring
// division on magnitudes over DATA_W cycles plus one sign-fix cycle.
// hi_out/lo_out change only on entry to DONE, so the Hi/Lo writeback never
// sees intermediate values.
module mult_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MULT_on,
  input  logic              DIV_on,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              dzero
);

  typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  // Two's complement negation; the most negative value wraps to itself.
  function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] v);
    return -v;
  endfunction

  // Magnitude of a two's complement value, read as unsigned.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? neg_val(v) : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // p_hi/p_lo hold the Booth product during multiply and the
  // remainder/quotient during divide; mcand holds multiplicand or |divisor|.
  logic [DATA_W-1:0]  p_hi_q, p_hi_d;
  logic [DATA_W-1:0]  p_lo_q, p_lo_d;
  logic               qm1_q, qm1_d;
  logic [DATA_W-1:0]  mcand_q, mcand_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               dz_q, dz_d;

  logic signed [DATA_W:0]  booth_hi_ext;
  logic signed [DATA_W:0]  booth_mc_ext;
  logic signed [DATA_W:0]  booth_sum;
  logic [DATA_W-1:0]       booth_hi;
  logic [DATA_W-1:0]       booth_lo;
  logic [DATA_W:0]         div_shift;
  logic [DATA_W:0]         div_trial;
  logic                    div_ge;
  logic [DATA_W-1:0]       div_rem;
  logic [DATA_W-1:0]       div_quo;

  // One Booth step and one restoring-divide step, computed from current state.
  always_comb begin
    booth_hi_ext = {p_hi_q[DATA_W-1], p_hi_q};
    booth_mc_ext = {mcand_q[DATA_W-1], mcand_q};
    // The add is one bit wider so the most negative multiplicand cannot overflow.
    case ({p_lo_q[0], qm1_q})
      2'b01:   booth_sum = booth_hi_ext + booth_mc_ext;
      2'b10:   booth_sum = booth_hi_ext - booth_mc_ext;
      default: booth_sum = booth_hi_ext;
    endcase
    booth_hi = booth_sum[DATA_W:1];
    booth_lo = {booth_sum[0], p_lo_q[DATA_W-1:1]};

    div_shift = {p_hi_q, p_lo_q[DATA_W-1]};
    div_trial = div_shift - {1'b0, mcand_q};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    div_rem   = div_ge ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
    div_quo   = {p_lo_q[DATA_W-2:0], div_ge};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (MULT_on) begin
          state_d = MUL_RUN;
          mcand_d = a_in;
          p_hi_d  = '0;
          p_lo_d  = b_in;
          qm1_d   = 1'b0;
          dz_d    = 1'b0;
        end else if (DIV_on) begin
          if (b_in == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV_RUN;
            mcand_d = abs_val(b_in);
            p_hi_d  = '0;
            p_lo_d  = abs_val(a_in);
            sa_d    = a_in[DATA_W-1];
            sb_d    = b_in[DATA_W-1];
            dz_d    = 1'b0;
          end
        end
      end
      MUL_RUN: begin
        p_hi_d = booth_hi;
        p_lo_d = booth_lo;
        qm1_d  = p_lo_q[0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          hi_d    = booth_hi;
          lo_d    = booth_lo;
        end
      end
      DIV_RUN: begin
        p_hi_d = div_rem;
        p_lo_d = div_quo;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        // Truncating division: remainder follows the dividend's sign.
        hi_d    = sa_q ? neg_val(p_hi_q) : p_hi_q;
        lo_d    = (sa_q ^ sb_q) ? neg_val(p_lo_q) : p_lo_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign dzero  = (state_q == DONE) && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset, multiply, divide, divide-by-zero,
// ignored starts, and reset abort.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        MULT_on;
  logic        DIV_on;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        dzero;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .MULT_on (MULT_on),
    .DIV_on  (DIV_on),
    .a_in    (a_in),
    .b_in    (b_in),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .busy    (busy),
    .done    (done),
    .dzero   (dzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start, scramble operands afterwards, and wait (bounded) for done.
  // On return the bench sits in the done cycle; lat = -1 means no done seen.
  task automatic run_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic hold_ok);
    logic [31:0] ph, pl;
    @(negedge clk);
    a_in = a; b_in = b; MULT_on = is_mul; DIV_on = !is_mul;
    ph = hi_out; pl = lo_out;
    @(negedge clk);
    MULT_on = 1'b0; DIV_on = 1'b0;
    a_in = $urandom; b_in = $urandom;
    lat = 1; busy_cnt = 0; hold_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (hi_out !== ph || lo_out !== pl) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    else if (busy) busy_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; MULT_on = 1'b0; DIV_on = 1'b0; a_in = '0; b_in = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want %h", hi_out, 32'h0); end
    n_cmp++; if (lo_out !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want %h", lo_out, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (dzero !== 1'b0) begin n_bad++; $display("FAIL reset_dzero got %b want 0", dzero); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult_basic();
    int lat, bc; logic hold;
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, lat, bc, hold);
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL mul_latency got %0d want 33", lat); end
    n_cmp++; if (hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mul_7x-3_hi got %h want ffffffff", hi_out); end
    n_cmp++; if (lo_out !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul_7x-3_lo got %h want ffffffeb", lo_out); end
    n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL mul_busy_cycles got %0d want 33", bc); end
    n_cmp++; if (dzero !== 1'b0) begin n_bad++; $display("FAIL mul_dzero got %b want 0", dzero); end
    n_cmp++; if (hold !== 1'b1) begin n_bad++; $display("FAIL mul_output_hold got %b want 1", hold); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mul_after_done busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_mult_extremes();
    int lat, bc; logic hold;
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, lat, bc, hold);
    n_cmp++; if (hi_out !== 32'h4000_0000 || lo_out !== 32'h0) begin n_bad++; $display("FAIL mul_minxmin got %h_%h want 40000000_00000000", hi_out, lo_out); end
    run_op(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, bc, hold);
    n_cmp++; if (hi_out !== 32'h3FFF_FFFF || lo_out !== 32'h0000_0001) begin n_bad++; $display("FAIL mul_maxxmax got %h_%h want 3fffffff_00000001", hi_out, lo_out); end
  endtask

  task automatic test_div();
    int lat, bc; logic hold;
    run_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, lat, bc, hold);
    n_cmp++; if (lat != 34) begin n_bad++; $display("FAIL div_latency got %0d want 34", lat); end
    n_cmp++; if (dzero !== 1'b0) begin n_bad++; $display("FAIL div_dzero got %b want 0", dzero); end
    n_cmp++; if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_-7/2 got q=%h r=%h want fffffffd/ffffffff", lo_out, hi_out); end
    n_cmp++; if (hold !== 1'b1) begin n_bad++; $display("FAIL div_output_hold got %b want 1", hold); end
    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFE, lat, bc, hold);
    n_cmp++; if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'h0000_0001) begin n_bad++; $display("FAIL div_7/-2 got q=%h r=%h want fffffffd/00000001", lo_out, hi_out); end
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, hold);
    n_cmp++; if (lo_out !== 32'h8000_0000 || hi_out !== 32'h0) begin n_bad++; $display("FAIL div_min/-1 got q=%h r=%h want 80000000/00000000", lo_out, hi_out); end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic hold;
    // 629 / 18 = 34 rem 17 leaves hi=0x11, lo=0x22.
    run_op(1'b0, 32'h0000_0275, 32'h0000_0012, lat, bc, hold);
    n_cmp++; if (lo_out !== 32'h22 || hi_out !== 32'h11) begin n_bad++; $display("FAIL div_setup got q=%h r=%h want 22/11", lo_out, hi_out); end
    run_op(1'b0, 32'h0000_0005, 32'h0000_0000, lat, bc, hold);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL dz_latency got %0d want 1", lat); end
    n_cmp++; if (dzero !== 1'b1) begin n_bad++; $display("FAIL dz_flag got %b want 1", dzero); end
    n_cmp++; if (hi_out !== 32'h11 || lo_out !== 32'h22) begin n_bad++; $display("FAIL dz_hold got %h/%h want 11/22", hi_out, lo_out); end
    @(negedge clk);
    n_cmp++; if (dzero !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL dz_pulse dzero=%b done=%b want 0/0", dzero, done); end
  endtask

  task automatic test_ignored_starts();
    int lat;
    @(negedge clk);
    a_in = 32'd6; b_in = 32'd5; MULT_on = 1'b1;
    @(negedge clk);
    MULT_on = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      // A divide-by-zero here would finish early with dzero if accepted.
      if (lat == 10) begin DIV_on = 1'b1; b_in = 32'h0; end
      else DIV_on = 1'b0;
      @(negedge clk);
      lat++;
    end
    DIV_on = 1'b0;
    if (!done) lat = -1;
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL ign_latency got %0d want 33", lat); end
    n_cmp++; if (hi_out !== 32'h0 || lo_out !== 32'h1E || dzero !== 1'b0) begin n_bad++; $display("FAIL ign_result got %h/%h dz=%b want 0/1e dz=0", hi_out, lo_out, dzero); end
    // Start in the DONE cycle must be dropped.
    a_in = 32'd9; b_in = 32'd9; MULT_on = 1'b1;
    @(negedge clk);
    MULT_on = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL ign_done_start busy=%b done=%b want 0/0", busy, done); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || lo_out !== 32'h1E) begin n_bad++; $display("FAIL ign_idle busy=%b lo=%h want 0/1e", busy, lo_out); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, seen; logic hold;
    @(negedge clk);
    a_in = 32'd100; b_in = 32'd7; DIV_on = 1'b1;
    @(negedge clk);
    DIV_on = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dzero !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0)
      begin n_bad++; $display("FAIL abort_clear busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, dzero, hi_out, lo_out); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", seen); end
    run_op(1'b1, 32'd3, 32'd4, lat, bc, hold);
    n_cmp++; if (lat != 33 || hi_out !== 32'h0 || lo_out !== 32'd12) begin n_bad++; $display("FAIL abort_then_mul lat=%0d hi=%h lo=%h want 33/0/c", lat, hi_out, lo_out); end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_extremes();
    test_div();
    test_div_zero();
    test_ignored_starts();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
